// File: rtl/branch_pkg.sv
// Shared branch/jump opcode codes, BHT counter type and helpers for the predictor slice.
// Pure declarations: no latency or backpressure of its own.
package branch_pkg;

    localparam logic [3:0] BJ_BEQ  = 4'b1000;
    localparam logic [3:0] BJ_BNE  = 4'b1001;
    localparam logic [3:0] BJ_JAL  = 4'b1011;
    localparam logic [3:0] BJ_BLT  = 4'b1100;
    localparam logic [3:0] BJ_BGE  = 4'b1101;
    localparam logic [3:0] BJ_BLTU = 4'b1110;
    localparam logic [3:0] BJ_BGEU = 4'b1111;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t SNT = 2'b00;
    localparam bht_ctr_t WNT = 2'b01;
    localparam bht_ctr_t WT  = 2'b10;
    localparam bht_ctr_t ST  = 2'b11;

    typedef struct packed {
        logic vld;
        logic taken;
        logic mispredict;
    } res_t;

    function automatic logic is_branch(input logic [3:0] bj_inst);
        logic hit;
        hit = 1'b0;
        case (bj_inst)
            BJ_BEQ, BJ_BNE, BJ_JAL, BJ_BLT, BJ_BGE, BJ_BLTU, BJ_BGEU: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic bht_ctr_t ctr_update(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'b01;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch/jump condition evaluator over XLEN-bit operands; purely combinational.
// Latency: 0 cycles; backpressure: none.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] inA,
    input  logic [XLEN-1:0] inB,
    input  logic [3:0]      bj_inst,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (bj_inst)
            BJ_BEQ:  taken = (inA == inB);
            BJ_BNE:  taken = (inA != inB);
            BJ_JAL:  taken = 1'b1;
            BJ_BLT:  taken = ($signed(inA) <  $signed(inB));
            BJ_BGE:  taken = ($signed(inA) >= $signed(inB));
            BJ_BLTU: taken = (inA <  inB);
            BJ_BGEU: taken = (inA >= inB);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch resolve + 2-bit BHT predictor with mispredict flag and saturating perf counters.
// Latency: prediction 0 cycles, resolve result 1 cycle; backpressure: none, one resolve per cycle.
module branch_predict_ctrl
    import branch_pkg::*;
#(
    parameter int       XLEN        = 32,
    parameter int       BHT_ENTRIES = 64,
    parameter int       PC_W        = 32,
    parameter int       CNT_W       = 16,
    parameter bht_ctr_t CTR_INIT    = WNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             fetch_pred_taken,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [3:0]       ex_bj_inst,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  inA,
    input  logic [XLEN-1:0]  inB,
    input  logic             flush,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bht_ctr_t         bht [BHT_ENTRIES];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             taken;
    logic             resolve;
    logic             mispredict;
    res_t             res_q;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .inA     (inA),
        .inB     (inB),
        .bj_inst (ex_bj_inst),
        .taken   (taken)
    );

    // Word-aligned PCs: bits [1:0] and the bits above the index never select an entry.
    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign ex_idx    = ex_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[PC_W-1:IDX_W+2], fetch_pc[1:0],
                              ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

    assign resolve    = ex_valid & ~flush & is_branch(ex_bj_inst);
    assign mispredict = taken ^ ex_pred_taken;

    // Read straight from the table: a same-cycle update is visible only after the edge.
    assign fetch_pred_taken = bht[fetch_idx][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (resolve) begin
            bht[ex_idx] <= ctr_update(bht[ex_idx], taken);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else begin
            res_q.vld        <= resolve;
            res_q.taken      <= resolve & taken;
            res_q.mispredict <= resolve & mispredict;
        end
    end

    assign res_valid      = res_q.vld;
    assign res_taken      = res_q.taken;
    assign res_mispredict = res_q.mispredict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count <= '0;
            mp_count <= '0;
        end else if (resolve) begin
            if (br_count != {CNT_W{1'b1}}) br_count <= br_count + CNT_W'(1);
            if (mispredict && (mp_count != {CNT_W{1'b1}})) mp_count <= mp_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed self-checking bench for branch_predict_ctrl (4-bit perf counters to reach saturation).
module tb_branch_predict_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [31:0]      fetch_pc;
    logic             fetch_pred_taken;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic [3:0]       ex_bj_inst;
    logic             ex_pred_taken;
    logic [31:0]      inA;
    logic [31:0]      inB;
    logic             flush;
    logic             res_valid;
    logic             res_taken;
    logic             res_mispredict;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    int tests;
    int fails;

    branch_predict_ctrl #(
        .XLEN(32), .BHT_ENTRIES(64), .PC_W(32), .CNT_W(CNT_W), .CTR_INIT(2'b01)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_bj_inst       (ex_bj_inst),
        .ex_pred_taken    (ex_pred_taken),
        .inA              (inA),
        .inB              (inB),
        .flush            (flush),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_mispredict   (res_mispredict),
        .br_count         (br_count),
        .mp_count         (mp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] bj,
                         input logic pt, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        ex_valid      = v;
        ex_pc         = pc;
        ex_bj_inst    = bj;
        ex_pred_taken = pt;
        inA           = a;
        inB           = b;
        flush         = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        fetch_pc = 32'h0;
        drive(1'b0, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        fetch_pc = 32'h100; #1;
        chk("rst_pred_100", fetch_pred_taken, 0);
        fetch_pc = 32'h3c; #1;
        chk("rst_pred_3c", fetch_pred_taken, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_br_count", br_count, 0);
        chk("rst_mp_count", mp_count, 0);

        // Signedness: -1 < 1 signed, but 0xFFFFFFFF > 1 unsigned
        drive(1'b1, 32'h204, 4'b1100, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        tick;
        chk("blt_valid", res_valid, 1);
        chk("blt_taken", res_taken, 1);
        chk("blt_mispredict", res_mispredict, 1);
        chk("blt_mp_count", mp_count, 1);
        chk("blt_br_count", br_count, 1);
        drive(1'b1, 32'h204, 4'b1110, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        tick;
        chk("bltu_valid", res_valid, 1);
        chk("bltu_taken", res_taken, 0);
        chk("bltu_mispredict", res_mispredict, 0);
        chk("bltu_mp_count", mp_count, 1);
        drive(1'b0, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
        tick;
        chk("idle_valid", res_valid, 0);
        chk("idle_br_count", br_count, 2);

        // Training at 0x100: 01 -> 10 -> 11 -> 11, then 10 -> 01
        fetch_pc = 32'h100;
        drive(1'b1, 32'h100, 4'b1000, 1'b1, 32'd5, 32'd5, 1'b0);
        #1 chk("train_pred_pre", fetch_pred_taken, 0);
        tick;
        chk("train_pred_t1", fetch_pred_taken, 1);
        chk("train_mp_t1", res_mispredict, 0);
        tick;
        chk("train_pred_t2", fetch_pred_taken, 1);
        tick;
        chk("train_pred_t3", fetch_pred_taken, 1);
        drive(1'b1, 32'h100, 4'b1000, 1'b1, 32'd5, 32'd6, 1'b0);
        tick;
        chk("train_pred_n1", fetch_pred_taken, 1);
        chk("train_taken_n1", res_taken, 0);
        chk("train_mp_n1", res_mispredict, 1);
        tick;
        chk("train_pred_n2", fetch_pred_taken, 0);
        chk("train_br_count", br_count, 7);
        chk("train_mp_count", mp_count, 3);

        // Collision: same index looked up and updated in one cycle
        fetch_pc = 32'h40;
        drive(1'b1, 32'h40, 4'b1000, 1'b0, 32'd9, 32'd9, 1'b0);
        #1 chk("coll_pred_same", fetch_pred_taken, 0);
        tick;
        drive(1'b0, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
        #1 chk("coll_pred_next", fetch_pred_taken, 1);
        chk("coll_br_count", br_count, 8);
        chk("coll_mp_count", mp_count, 4);

        // Flushed not-taken BNE would drop the 0x40 counter to 01 if it leaked
        drive(1'b1, 32'h40, 4'b1001, 1'b1, 32'd3, 32'd3, 1'b1);
        tick;
        chk("flush_valid", res_valid, 0);
        chk("flush_pred", fetch_pred_taken, 1);
        chk("flush_br_count", br_count, 8);
        chk("flush_mp_count", mp_count, 4);
        drive(1'b1, 32'h40, 4'b0101, 1'b1, 32'd3, 32'd4, 1'b0);
        tick;
        chk("nonbr_valid", res_valid, 0);
        chk("nonbr_br_count", br_count, 8);
        drive(1'b0, 32'h40, 4'b1000, 1'b1, 32'd3, 32'd4, 1'b0);
        tick;
        chk("invalid_valid", res_valid, 0);
        chk("invalid_pred", fetch_pred_taken, 1);

        // Saturation: 20 mispredicting JALs on 4-bit counters
        rst = 1'b1; #1;
        chk("rst2_br_count", br_count, 0);
        rst = 1'b0;
        fetch_pc = 32'h80;
        drive(1'b1, 32'h80, 4'b1011, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (15) tick;
        chk("sat_br_15", br_count, 15);
        chk("sat_mp_15", mp_count, 15);
        repeat (5) tick;
        chk("sat_br_hold", br_count, 15);
        chk("sat_mp_hold", mp_count, 15);
        chk("sat_res_valid", res_valid, 1);
        chk("sat_pred", fetch_pred_taken, 1);

        // Asynchronous reset between edges while a resolve is pending
        rst = 1'b1; #1;
        chk("arst_br_count", br_count, 0);
        chk("arst_mp_count", mp_count, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_pred", fetch_pred_taken, 0);
        #1 rst = 1'b0;
        tick;
        chk("post_arst_br", br_count, 1);
        drive(1'b0, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
